// File: rtl/serial_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_pkg
// Purpose  : Shared widths, FSM encodings and helpers for the serial tx/rx pair
// Revision : 1.0  initial release
// ============================================================================
package serial_pkg;

    localparam int W_DATA = 256;
    localparam int W_CNT  = 32;
    localparam int W_NB   = 8;

    localparam logic [1:0] TX_IDLE  = 2'd0;
    localparam logic [1:0] TX_SHIFT = 2'd1;
    localparam logic [1:0] TX_STOP  = 2'd2;

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_SHIFT = 2'd1;
    localparam logic [1:0] RX_CHECK = 2'd2;

    // Zero-valued timing/length settings are treated as one.
    function automatic logic [W_CNT-1:0] clamp1(input logic [W_CNT-1:0] v);
        return (v == '0) ? W_CNT'(1) : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_rx_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_rx_if
// Purpose  : Line, schedule and result signals of the serial receiver
// Revision : 1.0  initial release
// ============================================================================
interface serial_rx_if;
    import serial_pkg::*;

    logic              x;
    logic              x0;
    logic [W_NB-1:0]   nbits;
    logic [W_CNT-1:0]  n0;
    logic [W_CNT-1:0]  n1;
    logic [W_CNT-1:0]  cnt;
    logic [W_DATA-1:0] data;
    logic              valid;
    logic              busy;
    logic              err;

    modport master (
        input  x, x0, nbits, n0, n1, cnt,
        output data, valid, busy, err
    );

    modport slave (
        output x, x0, nbits, n0, n1, cnt,
        input  data, valid, busy, err
    );

endinterface
`default_nettype wire

// File: rtl/sync_ff.sv
`default_nettype none
// ============================================================================
// Module   : sync_ff
// Purpose  : Single-bit flop chain synchronizer with port-supplied reset value
// Revision : 1.0  initial release
// ============================================================================
module sync_ff #(
    parameter int DEPTH = 2
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_rst_val,
    input  wire logic i_d,
    output logic      o_q
);

    logic [DEPTH-1:0] r_pipe;

    generate
        if (DEPTH == 1) begin : g_single
            always_ff @(posedge clk or posedge rst) begin
                if (rst) r_pipe <= i_rst_val;
                else     r_pipe <= i_d;
            end
        end else begin : g_chain
            always_ff @(posedge clk or posedge rst) begin
                if (rst) r_pipe <= {DEPTH{i_rst_val}};
                else     r_pipe <= {r_pipe[DEPTH-2:0], i_d};
            end
        end
    endgenerate

    assign o_q = r_pipe[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/serial_rx.sv
`default_nettype none
// ============================================================================
// Module   : serial_rx
// Purpose  : Schedule-driven MSB-first serial receiver framed by shared cnt
// Revision : 1.0  initial release
// ============================================================================
module serial_rx
    import serial_pkg::*;
#(
    parameter int          P_SYNC_STAGES = 2,
    parameter int unsigned P_SAMPLE_OFS  = 0
) (
    input wire logic   clk,
    input wire logic   rst,
    serial_rx_if.master bus
);

    logic              w_xs;
    logic              w_hit;
    logic [W_CNT-1:0]  w_n0e;
    logic [W_CNT-1:0]  w_n1e;
    logic [W_NB-1:0]   w_nbe;
    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [W_NB-1:0]   r_nb;
    logic [W_NB-1:0]   r_bitcnt;
    logic [W_CNT-1:0]  r_n1;
    logic [W_CNT-1:0]  r_tgt;
    logic [W_DATA-1:0] r_sr;
    logic [W_DATA-1:0] r_data;
    logic              r_valid;
    logic              r_busy;
    logic              r_err;

    sync_ff #(.DEPTH(P_SYNC_STAGES)) u_sync (
        .clk      (clk),
        .rst      (rst),
        .i_rst_val(bus.x0),
        .i_d      (bus.x),
        .o_q      (w_xs)
    );

    assign w_n0e = clamp1(bus.n0);
    assign w_n1e = clamp1(bus.n1);
    assign w_nbe = W_NB'(clamp1(W_CNT'(bus.nbits)));
    assign w_hit = (bus.cnt == r_tgt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= RX_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RX_IDLE:  if (w_hit) w_state_nxt = (r_nb == W_NB'(1)) ? RX_CHECK : RX_SHIFT;
            RX_SHIFT: if (w_hit && (r_bitcnt == r_nb - W_NB'(1))) w_state_nxt = RX_CHECK;
            RX_CHECK: if (w_hit) w_state_nxt = RX_IDLE;
            default:  w_state_nxt = RX_IDLE;
        endcase
    end

    // Settings are re-latched every idle clock so a frame runs on a frozen copy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_nb     <= W_NB'(1);
            r_n1     <= W_CNT'(1);
            r_tgt    <= '0;
            r_bitcnt <= '0;
            r_sr     <= '0;
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                RX_IDLE: begin
                    r_nb     <= w_nbe;
                    r_n1     <= w_n1e;
                    r_tgt    <= w_n0e + (w_n1e >> 1) + W_CNT'(P_SAMPLE_OFS);
                    r_sr     <= '0;
                    r_bitcnt <= '0;
                    if (w_hit) begin
                        r_sr     <= W_DATA'(w_xs);
                        r_bitcnt <= W_NB'(1);
                        r_tgt    <= r_tgt + r_n1;
                        r_busy   <= 1'b1;
                    end
                end
                RX_SHIFT: begin
                    if (w_hit) begin
                        r_sr     <= {r_sr[W_DATA-2:0], w_xs};
                        r_bitcnt <= r_bitcnt + W_NB'(1);
                        r_tgt    <= r_tgt + r_n1;
                    end
                end
                RX_CHECK: begin
                    if (w_hit) begin
                        r_data  <= r_sr;
                        r_valid <= 1'b1;
                        r_err   <= (w_xs != bus.x0);
                        r_busy  <= 1'b0;
                    end
                end
                default: r_busy <= 1'b0;
            endcase
        end
    end

    assign bus.data  = r_data;
    assign bus.valid = r_valid;
    assign bus.busy  = r_busy;
    assign bus.err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_serial_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_rx
// Purpose  : Self-checking bench for serial_rx against a line/schedule model
// Revision : 1.0  initial release
// ============================================================================
module tb_serial_rx;
    import serial_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        x;
    logic        x0;
    logic [7:0]  nbits;
    logic [31:0] n0;
    logic [31:0] n1;
    logic [31:0] cnt;

    always #5 clk = ~clk;

    serial_rx_if bus_a();
    serial_rx_if bus_b();

    assign bus_a.x = x;  assign bus_a.x0 = x0;  assign bus_a.nbits = nbits;
    assign bus_a.n0 = n0; assign bus_a.n1 = n1; assign bus_a.cnt = cnt;
    assign bus_b.x = x;  assign bus_b.x0 = x0;  assign bus_b.nbits = nbits;
    assign bus_b.n0 = n0; assign bus_b.n1 = n1; assign bus_b.cnt = cnt;

    serial_rx #(.P_SYNC_STAGES(2), .P_SAMPLE_OFS(0)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    serial_rx #(.P_SYNC_STAGES(1), .P_SAMPLE_OFS(1)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    typedef struct {
        logic [7:0]   nb;
        logic [31:0]  a0;
        logic [31:0]  a1;
        logic [255:0] w;
        logic         post_inv;
        logic         idle;
        logic         exp_err;
        logic [255:0] exp_d;
        logic         ca;
        logic         cb;
    } vec_t;

    int           checks = 0;
    int           errors = 0;
    logic [31:0]  f_n0e, f_n1e, f_nbe;
    logic [255:0] f_word, f_exp_data;
    logic         f_post, f_exp_err, f_abort;
    logic [255:0] held [2];
    logic         known [2];
    logic         chk [2];
    string        nm [2] = '{"A", "B"};
    vec_t         tbl [5];

    task automatic cmp(input string what, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cnt=%0h got=%0h want=%0h", what, cnt, act, exp);
        end
    endtask

    // Transmitted line: idle before the frame, cell k carries word bit nb-1-k, then the post level.
    function automatic logic line_at(input logic [31:0] c);
        logic [31:0] rel;
        rel = c - f_n0e;
        if (rel < f_nbe * f_n1e) return f_word[8'(f_nbe - 32'd1 - rel / f_n1e)];
        else if (!rel[31])       return f_post;
        else                     return x0;
    endfunction

    function automatic logic [255:0] lowmask(input logic [31:0] nb);
        logic [255:0] m;
        m = '0;
        for (int i = 0; i < 256; i++) if (i < int'(nb)) m[i] = 1'b1;
        return m;
    endfunction

    task automatic check_one(input int id, input int ofs, input logic v, input logic b,
                             input logic e, input logic [255:0] d);
        logic [31:0] t0, span, dd;
        logic        ev, eb;
        if (!chk[id]) begin
            known[id] = 1'b0;
            return;
        end
        t0   = f_n0e + (f_n1e >> 1) + 32'(ofs);
        span = f_nbe * f_n1e;
        dd   = cnt - t0;
        ev   = !(rst || f_abort) && (dd == span);
        eb   = !(rst || f_abort) && (dd < span);
        if (rst) begin
            held[id]  = '0;
            known[id] = 1'b1;
        end else if (ev) begin
            held[id]  = f_exp_data;
            known[id] = 1'b1;
        end
        cmp({nm[id], ".valid"}, 256'(v), 256'(ev));
        cmp({nm[id], ".busy"},  256'(b), 256'(eb));
        cmp({nm[id], ".err"},   256'(e), 256'(ev & f_exp_err));
        if (known[id]) cmp({nm[id], ".data"}, d, held[id]);
    endtask

    task automatic step(input int n, input bit adv);
        repeat (n) begin
            @(negedge clk);
            check_one(0, 0, bus_a.valid, bus_a.busy, bus_a.err, bus_a.data);
            check_one(1, 1, bus_b.valid, bus_b.busy, bus_b.err, bus_b.data);
            if (adv) begin
                cnt = cnt + 32'd1;
                x   = line_at(cnt);
            end
        end
    endtask

    task automatic setup(input vec_t v);
        nbits      = v.nb;  n0 = v.a0;  n1 = v.a1;  x0 = v.idle;
        f_nbe      = (v.nb == 8'd0) ? 32'd1 : 32'(v.nb);
        f_n0e      = (v.a0 == 32'd0) ? 32'd1 : v.a0;
        f_n1e      = (v.a1 == 32'd0) ? 32'd1 : v.a1;
        f_word     = v.w;
        f_post     = v.post_inv ^ v.idle;
        f_exp_data = v.exp_d;
        f_exp_err  = v.exp_err;
        f_abort    = 1'b0;
        chk[0]     = v.ca;
        chk[1]     = v.cb;
        // Park cnt far from the new schedule while the settings settle.
        cnt = f_n0e + 32'h8000_0000;
        x   = v.idle;
        step(3, 1'b0);
        cnt = f_n0e - 32'd4;
        x   = line_at(cnt);
    endtask

    task automatic run_frame(input vec_t v);
        setup(v);
        step(16 + int'(f_nbe * f_n1e + f_n1e), 1'b1);
    endtask

    initial begin
        vec_t         r;
        logic [255:0] w;

        tbl[0] = '{8'd8,  32'd10,          32'd8,  256'hA5,   1'b0, 1'b0, 1'b0, 256'hA5,   1'b1, 1'b1};
        tbl[1] = '{8'd0,  32'd0,           32'd0,  256'h1,    1'b1, 1'b0, 1'b1, 256'h1,    1'b0, 1'b1};
        tbl[2] = '{8'd16, 32'd100,         32'd6,  256'hBEEF, 1'b1, 1'b1, 1'b1, 256'hBEEF, 1'b1, 1'b1};
        tbl[3] = '{8'd4,  32'hFFFF_FFF0,   32'd16, 256'h9,    1'b0, 1'b0, 1'b0, 256'h9,    1'b1, 1'b1};
        tbl[4] = '{8'd1,  32'd5,           32'd4,  256'h3,    1'b0, 1'b1, 1'b0, 256'h1,    1'b1, 1'b1};

        rst = 1'b1; x = 1'b0; x0 = 1'b0; nbits = 8'd8; n0 = 32'd10; n1 = 32'd8;
        cnt = 32'h8000_0000;
        f_n0e = 32'd10; f_n1e = 32'd8; f_nbe = 32'd8; f_word = '0; f_post = 1'b0;
        f_exp_data = '0; f_exp_err = 1'b0; f_abort = 1'b1;
        for (int i = 0; i < 2; i++) begin held[i] = '0; known[i] = 1'b1; chk[i] = 1'b1; end
        step(3, 1'b0);
        rst = 1'b0;
        step(3, 1'b0);

        for (int i = 0; i < 5; i++) run_frame(tbl[i]);

        // Full-length frame: 255 random bits, top data bit must stay clear.
        for (int k = 0; k < 8; k++) w[k*32 +: 32] = $urandom;
        r = '{8'd255, $urandom_range(50, 5000), 32'd4, w, 1'b0, 1'b0, 1'b0,
              w & lowmask(32'd255), 1'b1, 1'b1};
        run_frame(r);

        for (int t = 0; t < 12; t++) begin
            for (int k = 0; k < 8; k++) w[k*32 +: 32] = $urandom;
            r.nb       = 8'($urandom_range(1, 40));
            r.a0       = $urandom;
            r.a1       = $urandom_range(4, 12);
            r.w        = w;
            r.post_inv = 1'($urandom_range(0, 1));
            r.idle     = 1'($urandom_range(0, 1));
            r.exp_err  = r.post_inv;
            r.exp_d    = w & lowmask(32'(r.nb));
            r.ca       = 1'b1;
            r.cb       = 1'b1;
            run_frame(r);
        end

        // Reset after five bits of an 8-bit frame: nothing may be reported for it.
        r = '{8'd8, 32'd10, 32'd8, 256'h5A, 1'b0, 1'b0, 1'b0, 256'h5A, 1'b1, 1'b1};
        setup(r);
        step(4 + 4 + 4 * 8 + 2, 1'b1);
        rst     = 1'b1;
        f_abort = 1'b1;
        step(4, 1'b1);
        rst = 1'b0;
        step(80, 1'b1);
        run_frame('{8'd8, 32'd10, 32'd8, 256'h3C, 1'b0, 1'b0, 1'b0, 256'h3C, 1'b1, 1'b1});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
